// File: rtl/rpn_seq_ctrl.sv
// rpn_seq_ctrl: RPN token sequencer. Number tokens are pushed onto a small
// operand stack; arithmetic tokens hand the top two entries to an external
// ALU and replace them with its result; POP prints and drops the top entry.
// Every arithmetic result or popped value is offered to a printer before the
// next token is accepted.
module rpn_seq_ctrl #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tok_valid,
   output logic                     tok_ready,
   input  logic                     tok_is_op,
   input  logic [3:0]               tok_op,
   input  logic [WIDTH-1:0]         tok_num,
   output logic                     alu_req,
   output logic [1:0]               alu_op,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   input  logic                     alu_ack,
   input  logic [WIDTH-1:0]         alu_res,
   input  logic                     alu_err,
   output logic                     prt_valid,
   output logic [WIDTH-1:0]         prt_data,
   input  logic                     prt_ready,
   output logic                     err_valid,
   output logic [1:0]               err_code,
   output logic [$clog2(DEPTH):0]   depth
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW = $clog2(DEPTH) + 1;

   localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
   localparam logic [1:0] ERR_ARITH     = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_PRINT
   } state_t;

   state_t           r_state;
   logic [DW-1:0]    r_depth;
   logic [WIDTH-1:0] r_stack [DEPTH];
   logic             r_tok_ready;
   logic             r_alu_req;
   logic [1:0]       r_alu_op;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic             r_prt_valid;
   logic [WIDTH-1:0] r_prt_data;
   logic             r_err_valid;
   logic [1:0]       r_err_code;

   logic             w_accept;
   logic             w_full;
   logic             w_is_arith;
   logic             w_is_pop;
   logic [AW-1:0]    w_top_idx;
   logic [AW-1:0]    w_sec_idx;
   logic [AW-1:0]    w_push_idx;
   logic             w_wr_en;
   logic [AW-1:0]    w_wr_idx;
   logic [WIDTH-1:0] w_wr_data;

   // Token decode and stack addressing; indices are only used when depth makes them valid.
   always_comb begin
      w_accept   = (r_state == S_IDLE) && r_tok_ready && tok_valid;
      w_full     = (r_depth == DW'(DEPTH));
      w_is_arith = (tok_op < 4'd4);
      w_is_pop   = (tok_op == 4'd4);
      w_top_idx  = AW'(r_depth - DW'(1));
      w_sec_idx  = AW'(r_depth - DW'(2));
      w_push_idx = AW'(r_depth);
   end

   // Stack write port: a number push, or an ALU result overwriting the second entry.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_idx  = '0;
      w_wr_data = '0;
      if (w_accept && !tok_is_op && !w_full) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = w_push_idx;
         w_wr_data = tok_num;
      end else if ((r_state == S_EXEC) && alu_ack && !alu_err) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = w_sec_idx;
         w_wr_data = alu_res;
      end
   end

   // Stack storage: not reset, entries above depth are never read.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_stack[w_wr_idx] <= w_wr_data;
      end
   end

   // Control FSM with registered handshake, ALU, print and error outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_depth     <= '0;
         r_tok_ready <= 1'b0;
         r_alu_req   <= 1'b0;
         r_alu_op    <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_prt_valid <= 1'b0;
         r_prt_data  <= '0;
         r_err_valid <= 1'b0;
         r_err_code  <= '0;
      end else begin
         r_err_valid <= 1'b0;
         r_err_code  <= '0;
         case (r_state)
            S_IDLE: begin
               r_tok_ready <= 1'b1;
               if (w_accept) begin
                  if (!tok_is_op) begin
                     if (w_full) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_OVERFLOW;
                     end else begin
                        r_depth <= r_depth + DW'(1);
                     end
                  end else if (w_is_arith) begin
                     if (r_depth < DW'(2)) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_UNDERFLOW;
                     end else begin
                        r_state     <= S_EXEC;
                        r_tok_ready <= 1'b0;
                        r_alu_req   <= 1'b1;
                        r_alu_op    <= tok_op[1:0];
                        r_alu_a     <= r_stack[w_sec_idx];
                        r_alu_b     <= r_stack[w_top_idx];
                     end
                  end else if (w_is_pop) begin
                     if (r_depth == '0) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_UNDERFLOW;
                     end else begin
                        r_depth     <= r_depth - DW'(1);
                        r_prt_valid <= 1'b1;
                        r_prt_data  <= r_stack[w_top_idx];
                        r_state     <= S_PRINT;
                        r_tok_ready <= 1'b0;
                     end
                  end else begin
                     r_err_valid <= 1'b1;
                     r_err_code  <= ERR_ARITH;
                  end
               end
            end
            S_EXEC: begin
               if (alu_ack) begin
                  r_alu_req <= 1'b0;
                  if (alu_err) begin
                     r_err_valid <= 1'b1;
                     r_err_code  <= ERR_ARITH;
                     r_state     <= S_IDLE;
                     r_tok_ready <= 1'b1;
                  end else begin
                     r_depth     <= r_depth - DW'(1);
                     r_prt_valid <= 1'b1;
                     r_prt_data  <= alu_res;
                     r_state     <= S_PRINT;
                  end
               end
            end
            S_PRINT: begin
               if (prt_ready) begin
                  r_prt_valid <= 1'b0;
                  r_state     <= S_IDLE;
                  r_tok_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_tok_ready <= 1'b0;
            end
         endcase
      end
   end

   assign tok_ready = r_tok_ready;
   assign alu_req   = r_alu_req;
   assign alu_op    = r_alu_op;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign prt_valid = r_prt_valid;
   assign prt_data  = r_prt_data;
   assign err_valid = r_err_valid;
   assign err_code  = r_err_code;
   assign depth     = r_depth;

endmodule

// File: doc/rpn_seq_ctrl.md
RPN_SEQ_CTRL -- requirements
Module: rpn_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of stack entries.
REQ-002 Parameter WIDTH, default 16: operand and result width in bits.
REQ-003 The block SHALL use a single clock `clk` and an asynchronous, active-low reset `rst_n`, with ports as follows:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- tok_valid  input  1  token present
- tok_ready  output  1  block accepts a token this cycle
- tok_is_op  input  1  1 = operator token, 0 = number token
- tok_op  input  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 POP, others unknown
- tok_num  input  WIDTH  number value
- alu_req  output  1  ALU request
- alu_op  output  2  0 add, 1 sub, 2 mul, 3 div
- alu_a / alu_b  output  WIDTH  operands (a = second from top, b = top)
- alu_ack  input  1  ALU result valid
- alu_res  input  WIDTH  ALU result
- alu_err  input  1  ALU error (for example divide by zero), sampled with alu_ack
- prt_valid  output  1  print data valid
- prt_data  output  WIDTH  value to print
- prt_ready  input  1  printer accepts data
- err_valid  output  1  one-cycle error pulse
- err_code  output  2  1 underflow, 2 overflow, 3 arithmetic or unknown operator
- depth  output  $clog2(DEPTH)+1  current stack occupancy

Function
REQ-004 The block SHALL implement a state machine with states IDLE, EXEC and PRINT.
REQ-005 tok_ready SHALL be 1 only in IDLE; a token is accepted when tok_valid and tok_ready are both 1 on a rising edge.
REQ-006 tok_valid outside IDLE SHALL be ignored; such a token is not consumed.
REQ-007 Number token, depth < DEPTH: tok_num SHALL be pushed and depth SHALL increment, visible the next cycle; the state stays IDLE.
REQ-008 Number token, depth == DEPTH: the value SHALL be discarded, depth SHALL stay unchanged, and err_valid=1 with err_code=2 SHALL be driven for one cycle.
REQ-009 ADD/SUB/MUL/DIV token, depth < 2: the stack SHALL stay unchanged, err_valid=1 with err_code=1 SHALL be driven for one cycle, alu_req SHALL not assert, and the state stays IDLE.
REQ-010 ADD/SUB/MUL/DIV token, depth >= 2: the block SHALL enter EXEC the next cycle with alu_req=1, alu_op = tok_op[1:0], alu_a = entry[depth-2] and alu_b = entry[depth-1].
REQ-011 In EXEC, alu_req, alu_op, alu_a and alu_b SHALL hold stable until the cycle in which alu_ack=1; alu_ack while alu_req=0 SHALL be ignored.
REQ-012 alu_ack with alu_err=0 SHALL cause the two top entries to be replaced by alu_res (depth decrements by 1), alu_req to deassert, and the block to enter PRINT with prt_data = alu_res on the next cycle.
REQ-013 alu_ack with alu_err=1 SHALL leave the stack unchanged, pulse err_valid with err_code=3, skip printing and return to IDLE.
REQ-014 POP token, depth == 0: the block SHALL pulse err_valid with err_code=1 and stay in IDLE.
REQ-015 POP token, depth >= 1: depth SHALL decrement and the block SHALL enter PRINT with prt_data = the popped top entry.
REQ-016 Unknown operator (tok_op >= 5): the block SHALL pulse err_valid with err_code=3, leave the stack unchanged and stay in IDLE.
REQ-017 In PRINT, prt_valid SHALL be 1 and prt_data SHALL be held stable until prt_ready=1; on that edge prt_valid SHALL clear and the state SHALL return to IDLE.
REQ-018 prt_ready=1 on the same edge that PRINT is entered SHALL have no effect; prt_valid SHALL be high for at least one cycle.
REQ-019 err_valid SHALL be high for exactly one cycle per error; err_code SHALL be 0 whenever err_valid=0.
REQ-020 depth SHALL never exceed DEPTH and SHALL never go below 0.
REQ-021 Arithmetic SHALL be performed by the external ALU only; the block SHALL not modify WIDTH-bit results.

Reset
REQ-022 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, enter IDLE and drive depth=0, tok_ready=0, alu_req=0, alu_op=0, alu_a=0, alu_b=0, prt_valid=0, prt_data=0, err_valid=0 and err_code=0.
REQ-023 tok_ready SHALL assert on the first rising edge after rst_n deasserts.
REQ-024 Reset asserted in EXEC or PRINT SHALL abandon the operation; a late alu_ack or prt_ready after reset SHALL be ignored.
REQ-025 Stack entry contents need not be cleared by reset, but SHALL be unobservable until pushed again.

Verification
REQ-026 The bench SHALL cover: push 3, push 4, ADD; ALU acks res=7 after 3 cycles -> alu_a=3, alu_b=4, alu_op=0 stable for 3 cycles; prt_data=7; depth=1.
REQ-027 The bench SHALL cover: empty stack, SUB -> err_valid one cycle with code 1; no alu_req; depth=0; tok_ready=1 the next cycle.
REQ-028 The bench SHALL cover: 9 pushes of 1..9 -> the 9th push pulses err_code=2; depth=8; top entry still 8.
REQ-029 The bench SHALL cover: push 5, push 0, DIV; ALU acks with alu_err=1 -> err_code=3; depth=2; no prt_valid.
REQ-030 The bench SHALL cover: depth=1 holding 7, POP with prt_ready low for 5 cycles -> prt_valid high for 6 cycles with prt_data=7; depth=0; a token offered meanwhile is not consumed.
REQ-031 The bench SHALL cover: reset asserted in EXEC before alu_ack -> alu_req=0 and depth=0 immediately; a subsequent alu_ack is ignored.
